// File: rtl/blinker_if.sv
// Settings/LED bundle between the IO multiplexer (master) and the blinker (slave).
interface blinker_if;
  logic [31:0] custom_settings;
  logic [2:0]  blinker_do;

  modport master (output custom_settings, input blinker_do);
  modport slave  (input custom_settings, output blinker_do);
endinterface

// File: rtl/blinker.sv
// Three-channel LED pattern generator: prescaler + step divider pacing a count,
// bounce, PWM breathe or static pattern, with a per-channel output invert mask.
module blinker #(
  parameter int DIV_W = 16
) (
  input  logic     wb_clk_i,
  input  logic     rst_n,
  blinker_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_BOUNCE  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_STATIC  = 2'd3
  } mode_t;

  logic [7:0] p;
  mode_t      mode_in;
  logic [2:0] static_pat;
  logic [2:0] inv;
  logic       en;
  logic       unused_bits;

  assign p          = bus.custom_settings[7:0];
  assign mode_in    = mode_t'(bus.custom_settings[9:8]);
  assign static_pat = bus.custom_settings[12:10];
  assign inv        = bus.custom_settings[15:13];
  assign en         = bus.custom_settings[16];
  assign unused_bits = ^bus.custom_settings[31:17];

  logic [7:0]       presc, presc_n;
  logic [DIV_W-1:0] divider, divider_n;
  logic [2:0]       cnt3, cnt3_n;
  logic [2:0]       pos, pos_n;
  logic             dir, dir_n;
  logic [7:0]       duty, duty_n;
  logic [7:0]       pwm_cnt, pwm_cnt_n;
  mode_t            mode_q, mode_q_n;
  logic [2:0]       do_q, do_n;

  logic       mode_change;
  logic       tick;
  logic       step;
  logic [2:0] pattern;

  assign mode_change = (mode_in != mode_q);
  assign tick        = (presc == 8'd0);
  assign step        = en && tick && (&divider) && !mode_change;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      divider <= '0;
      cnt3    <= '0;
      pos     <= 3'b001;
      dir     <= 1'b0;
      duty    <= '0;
      pwm_cnt <= '0;
      mode_q  <= MODE_COUNT;
      do_q    <= '0;
    end else begin
      presc   <= presc_n;
      divider <= divider_n;
      cnt3    <= cnt3_n;
      pos     <= pos_n;
      dir     <= dir_n;
      duty    <= duty_n;
      pwm_cnt <= pwm_cnt_n;
      mode_q  <= mode_q_n;
      do_q    <= do_n;
    end
  end

  // dir is shared by bounce and breathe; only the active mode ever moves it.
  always_comb begin
    presc_n   = presc;
    divider_n = divider;
    cnt3_n    = cnt3;
    pos_n     = pos;
    dir_n     = dir;
    duty_n    = duty;
    pwm_cnt_n = pwm_cnt;
    mode_q_n  = mode_q;

    if (mode_change) begin
      presc_n   = p;
      divider_n = '0;
      cnt3_n    = '0;
      pos_n     = 3'b001;
      dir_n     = 1'b0;
      duty_n    = '0;
      pwm_cnt_n = '0;
      mode_q_n  = mode_in;
    end else if (en) begin
      presc_n   = tick ? p : presc - 8'd1;
      pwm_cnt_n = pwm_cnt + 8'd1;
      if (tick)
        divider_n = divider + DIV_W'(1);
      if (step) begin
        case (mode_q)
          MODE_COUNT: cnt3_n = cnt3 + 3'd1;
          MODE_BOUNCE: begin
            if (!dir) begin
              if (pos == 3'b100) begin
                dir_n = 1'b1;
                pos_n = 3'b010;
              end else begin
                pos_n = pos << 1;
              end
            end else begin
              if (pos == 3'b001) begin
                dir_n = 1'b0;
                pos_n = 3'b010;
              end else begin
                pos_n = pos >> 1;
              end
            end
          end
          MODE_BREATHE: begin
            if (!dir) begin
              if (duty == 8'd255) begin
                dir_n  = 1'b1;
                duty_n = 8'd254;
              end else begin
                duty_n = duty + 8'd1;
              end
            end else begin
              if (duty == 8'd0) begin
                dir_n  = 1'b0;
                duty_n = 8'd1;
              end else begin
                duty_n = duty - 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Pattern is decoded from the registered mode so pins lag state by exactly one clock.
  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_COUNT:   pattern = cnt3;
      MODE_BOUNCE:  pattern = pos;
      MODE_BREATHE: pattern = {duty[7], (pwm_cnt < ~duty), (pwm_cnt < duty)};
      MODE_STATIC:  pattern = static_pat;
      default:      pattern = '0;
    endcase
    do_n = pattern ^ inv;
  end

  assign bus.blinker_do = do_q;

endmodule

// File: tb/tb_blinker.sv
// Self-checking bench for blinker: directed scenarios plus randomized settings,
// compared every clock against a closed-form model of step count and patterns.
module tb_blinker;
  localparam int DIV_W = 2;

  logic wb_clk_i = 1'b0;
  logic rst_n    = 1'b0;

  blinker_if bif ();

  blinker #(.DIV_W(DIV_W)) dut (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .bus      (bif.slave)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int errors = 0;
  int checks = 0;

  logic [7:0]  s_p    = '0;
  logic [1:0]  s_mode = '0;
  logic [2:0]  s_stat = '0;
  logic [2:0]  s_inv  = '0;
  logic        s_en   = 1'b0;
  logic [14:0] s_junk = '0;

  // Model: k = enabled clocks since the last reset/mode change, off = tick phase offset.
  int m_mode = 0;
  int m_k    = 0;
  int m_off  = 0;
  int m_p    = 0;

  task automatic apply_stimulus();
    bif.custom_settings = {s_junk, s_en, s_inv, s_stat, s_mode, s_p};
  endtask

  task automatic check_output(input string tag, input logic [2:0] observed,
                              input logic [2:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  function automatic logic [2:0] model_pattern();
    int ticks, s, t, duty, pwm;
    ticks = (m_k + m_off) / (m_p + 1);
    s     = ticks / (1 << DIV_W);
    case (m_mode)
      0: return 3'(s % 8);
      1: begin
        case (s % 4)
          0:       return 3'b001;
          1:       return 3'b010;
          2:       return 3'b100;
          default: return 3'b010;
        endcase
      end
      2: begin
        t    = s % 510;
        duty = (t <= 255) ? t : 510 - t;
        pwm  = m_k % 256;
        return {(duty >= 128), (pwm < 255 - duty), (pwm < duty)};
      end
      default: return s_stat;
    endcase
  endfunction

  task automatic clk_step(input string tag);
    logic [2:0] exp_do;
    exp_do = model_pattern() ^ s_inv;
    if (int'(s_mode) != m_mode) begin
      m_mode = int'(s_mode);
      m_k    = 0;
      m_off  = 0;
      m_p    = int'(s_p);
    end else if (s_en) begin
      m_k++;
    end
    @(posedge wb_clk_i);
    #1;
    check_output(tag, bif.blinker_do, exp_do);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) clk_step(tag);
  endtask

  // Assert reset between edges, confirm async clear, release mid-cycle.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("reset_async", bif.blinker_do, 3'b000);
    @(posedge wb_clk_i);
    #1;
    check_output("reset_hold", bif.blinker_do, 3'b000);
    #3;
    rst_n  = 1'b1;
    m_mode = 0;
    m_k    = 0;
    m_p    = int'(s_p);
    m_off  = m_p;
  endtask

  initial begin
    int n;
    logic [1:0] new_mode;

    // Reset with everything inverted: pins stay 000 in reset, 111 after.
    s_p = 8'd1; s_mode = 2'd0; s_stat = 3'b000; s_inv = 3'b111; s_en = 1'b1;
    s_junk = 15'($urandom);
    apply_stimulus();
    #1;
    check_output("reset_initial", bif.blinker_do, 3'b000);
    do_reset();
    clk_step("first_edge");

    // Count mode at P=1: step every 8 clocks, wrap after 64.
    s_inv = 3'b000;
    apply_stimulus();
    run("count_p1", 140);

    // Bounce at P=0 through both direction flips.
    s_mode = 2'd1; s_p = 8'd0;
    apply_stimulus();
    run("bounce", 40);

    // Breathe across a full up/down ramp and into the next one.
    s_mode = 2'd2;
    apply_stimulus();
    run("breathe", 2100);

    // Count mid-sequence, then static 101, then back to count from zero.
    s_mode = 2'd0; s_p = 8'd3;
    apply_stimulus();
    run("count_p3", 37);
    s_mode = 2'd3; s_stat = 3'b101;
    apply_stimulus();
    run("static", 6);
    s_mode = 2'd0;
    apply_stimulus();
    run("count_restart", 25);

    // Freeze with EN low while INV keeps acting on the held state.
    s_en = 1'b0;
    apply_stimulus();
    run("en_freeze", 50);
    s_inv = 3'b010;
    apply_stimulus();
    run("en_freeze_inv", 50);
    s_en = 1'b1;
    apply_stimulus();
    run("en_resume", 30);

    // Async reset dropped mid-step.
    s_inv = 3'b110;
    apply_stimulus();
    do_reset();
    run("after_reset", 40);

    // Randomized segments; P only changes together with a mode change.
    for (int seg = 0; seg < 40; seg++) begin
      new_mode = 2'($urandom_range(0, 3));
      if (new_mode != s_mode) s_p = 8'($urandom_range(0, 3));
      s_mode = new_mode;
      s_stat = 3'($urandom);
      s_inv  = 3'($urandom);
      s_junk = 15'($urandom);
      s_en   = ($urandom_range(0, 4) != 0);
      apply_stimulus();
      n = $urandom_range(20, 150);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          s_inv  = 3'($urandom);
          s_stat = 3'($urandom);
          s_en   = ~s_en;
          apply_stimulus();
        end
        clk_step("random");
      end
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
